// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging pipeline and late results onto one register-file write port
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_valid,
    input  logic [4:0]               pipe_rd,
    input  logic [XLEN-1:0]          pipe_data,
    input  logic                     late_valid,
    output logic                     late_ready,
    input  logic [4:0]               late_rd,
    input  logic [XLEN-1:0]          late_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic [4:0]               chk_addr1,
    input  logic [4:0]               chk_addr2,
    output logic                     hazard,
    output logic                     rg_wrt_en,
    output logic [4:0]               rg_wrt_addr,
    output logic [XLEN-1:0]          rg_wrt_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      fifo_rd   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            src_late;
    logic [31:0]     pending;
    logic [31:0]     pending_next;
    logic            push;
    logic            pop;

    assign late_ready = !reset && (fifo_count < CW'(DEPTH));
    assign push       = late_valid && late_ready;
    // The pipeline has no backpressure, so the FIFO only drains on idle pipe cycles.
    assign pop        = !pipe_valid && (fifo_count != '0);
    assign hazard     = pending[chk_addr1] | pending[chk_addr2];

    always_comb begin
        pending_next = pending;
        if (rg_wrt_en && src_late)
            pending_next[rg_wrt_addr] = 1'b0;
        // Set after clear so a reissue to the same register on the commit edge survives.
        if (issue_valid && (issue_rd != 5'd0))
            pending_next[issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= late_rd;
            fifo_data[wr_ptr] <= late_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= 5'd0;
            rg_wrt_data <= '0;
            src_late    <= 1'b0;
            pending     <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (pipe_valid) begin
                rg_wrt_en   <= (pipe_rd != 5'd0);
                rg_wrt_addr <= pipe_rd;
                rg_wrt_data <= pipe_data;
                src_late    <= 1'b0;
            end else if (pop) begin
                rg_wrt_en   <= (fifo_rd[rd_ptr] != 5'd0);
                rg_wrt_addr <= fifo_rd[rd_ptr];
                rg_wrt_data <= fifo_data[rd_ptr];
                src_late    <= 1'b1;
            end else begin
                rg_wrt_en   <= 1'b0;
                src_late    <= 1'b0;
            end

            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        late_valid = 1'b0;
    logic        late_ready;
    logic [4:0]  late_rd = '0;
    logic [31:0] late_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  chk_addr1 = '0;
    logic [4:0]  chk_addr2 = '0;
    logic        hazard;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_addr;
    logic [31:0] rg_wrt_data;
    logic [1:0]  fifo_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic        pv;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_en;
    } vec_t;
    vec_t vecs[5];

    wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .late_valid(late_valid), .late_ready(late_ready), .late_rd(late_rd), .late_data(late_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard(hazard),
        .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr), .rg_wrt_data(rg_wrt_data),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every register-file write must match the next expected write, in order.
    always @(negedge clk) begin
        if (!reset && rg_wrt_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {27'd0, rg_wrt_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_addr", {27'd0, rg_wrt_addr}, {27'd0, e.rd});
                check("sb_data", rg_wrt_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] lrd [3];
        int idx;
        bit acc;
        bit drained;

        vecs[0] = '{pv: 1'b1, rd: 5'd5,  data: 32'hDEAD_BEEF, exp_en: 1'b1};
        vecs[1] = '{pv: 1'b1, rd: 5'd0,  data: 32'h1111_1111, exp_en: 1'b0};
        vecs[2] = '{pv: 1'b0, rd: 5'd6,  data: 32'h2222_2222, exp_en: 1'b0};
        vecs[3] = '{pv: 1'b1, rd: 5'd31, data: 32'hA5A5_5A5A, exp_en: 1'b1};
        vecs[4] = '{pv: 1'b1, rd: 5'd1,  data: 32'h0000_0001, exp_en: 1'b1};

        // Reset state
        step(); step(); step();
        check("reset_late_ready", {31'd0, late_ready}, 32'd0);
        check("reset_wrt_en", {31'd0, rg_wrt_en}, 32'd0);
        check("reset_wrt_addr", {27'd0, rg_wrt_addr}, 32'd0);
        check("reset_wrt_data", rg_wrt_data, 32'd0);
        check("reset_fifo_count", {30'd0, fifo_count}, 32'd0);
        reset = 1'b0;
        step();
        check("post_reset_late_ready", {31'd0, late_ready}, 32'd1);
        for (int a = 0; a < 32; a++) begin
            chk_addr1 = 5'(a);
            chk_addr2 = 5'(31 - a);
            #1;
            check("post_reset_hazard", {31'd0, hazard}, 32'd0);
        end
        chk_addr1 = '0;
        chk_addr2 = '0;

        // Pipe-only vectors
        for (int i = 0; i < 5; i++) begin
            pipe_valid = vecs[i].pv;
            pipe_rd    = vecs[i].rd;
            pipe_data  = vecs[i].data;
            if (vecs[i].exp_en)
                exp_q.push_back('{rd: vecs[i].rd, data: vecs[i].data});
            step();
            check("vec_wrt_en", {31'd0, rg_wrt_en}, {31'd0, vecs[i].exp_en});
            if (vecs[i].exp_en) begin
                check("vec_wrt_addr", {27'd0, rg_wrt_addr}, {27'd0, vecs[i].rd});
                check("vec_wrt_data", rg_wrt_data, vecs[i].data);
            end
        end
        pipe_valid = 1'b0;
        step();

        // Late path with hazard tracking on x7
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        chk_addr1 = 5'd7; chk_addr2 = 5'd0;
        #1;
        check("late_hazard_after_issue", {31'd0, hazard}, 32'd1);
        late_valid = 1'b1; late_rd = 5'd7; late_data = 32'h1234;
        exp_q.push_back('{rd: 5'd7, data: 32'h1234});
        step();
        late_valid = 1'b0;
        check("late_count_after_push", {30'd0, fifo_count}, 32'd1);
        check("late_no_write_yet", {31'd0, rg_wrt_en}, 32'd0);
        step();
        check("late_write_en", {31'd0, rg_wrt_en}, 32'd1);
        check("late_hazard_until_commit", {31'd0, hazard}, 32'd1);
        step();
        check("late_hazard_cleared", {31'd0, hazard}, 32'd0);
        chk_addr1 = 5'd0;
        #1;
        check("x0_never_hazard", {31'd0, hazard}, 32'd0);

        // Pipeline priority with FIFO backpressure
        lrd[0] = 5'd20; lrd[1] = 5'd21; lrd[2] = 5'd22;
        for (int p = 0; p < 4; p++)
            exp_q.push_back('{rd: 5'(10 + p), data: 32'h1000 + 32'(p)});
        for (int l = 0; l < 3; l++)
            exp_q.push_back('{rd: lrd[l], data: 32'h2000 + 32'(l)});
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx >= 3 && c >= 4) break;
            pipe_valid = (c < 4);
            pipe_rd    = 5'(10 + c);
            pipe_data  = 32'h1000 + 32'(c);
            late_valid = (idx < 3);
            late_rd    = (idx < 3) ? lrd[idx] : 5'd0;
            late_data  = 32'h2000 + 32'(idx);
            #1;
            if (c == 2) begin
                check("bp_late_ready_full", {31'd0, late_ready}, 32'd0);
                check("bp_fifo_full", {30'd0, fifo_count}, 32'd2);
            end
            if (c == 3)
                check("bp_still_held", {31'd0, late_ready}, 32'd0);
            acc = late_valid && late_ready;
            step();
            if (acc) idx++;
        end
        pipe_valid = 1'b0;
        late_valid = 1'b0;
        drained = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (fifo_count == 0 && !rg_wrt_en) begin
                drained = 1'b1;
                break;
            end
            step();
        end
        check("bp_all_accepted", 32'(idx), 32'd3);
        check("bp_drained", {31'd0, drained}, 32'd1);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Set and clear of x9 on the same edge
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        late_valid = 1'b1; late_rd = 5'd9; late_data = 32'h99;
        exp_q.push_back('{rd: 5'd9, data: 32'h99});
        step();
        late_valid = 1'b0;
        step();
        check("sc_commit_cycle", {31'd0, rg_wrt_en}, 32'd1);
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        chk_addr2 = 5'd9;
        #1;
        check("sc_set_wins", {31'd0, hazard}, 32'd1);
        late_valid = 1'b1; late_rd = 5'd9; late_data = 32'h999;
        exp_q.push_back('{rd: 5'd9, data: 32'h999});
        step();
        late_valid = 1'b0;
        step(); step();
        check("sc_second_clear", {31'd0, hazard}, 32'd0);
        chk_addr2 = 5'd0;

        // Reset with FIFO full and three pending bits
        for (int r = 3; r <= 5; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            step();
        end
        issue_valid = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd0;
        for (int l = 0; l < 2; l++) begin
            late_valid = 1'b1; late_rd = 5'(3 + l); late_data = 32'hBAD0 + 32'(l);
            step();
        end
        late_valid = 1'b0;
        check("rst_fifo_full", {30'd0, fifo_count}, 32'd2);
        chk_addr1 = 5'd3; chk_addr2 = 5'd5;
        #1;
        check("rst_pending_before", {31'd0, hazard}, 32'd1);
        pipe_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_fifo_cleared", {30'd0, fifo_count}, 32'd0);
        check("rst_hazard_cleared", {31'd0, hazard}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_no_stale_write", {31'd0, rg_wrt_en}, 32'd0);
        end
        chk_addr1 = 5'd4;
        #1;
        check("rst_x4_cleared", {31'd0, hazard}, 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
